// File: rtl/ascon_req_arbiter.sv
// ascon_req_arbiter
//   Shares one ascon AEAD core between NumReq requesters. The core is granted
//   round-robin for one complete job at a time (start through tag). The winner's
//   key/nonce/sizes are latched when it wins. The core's FIFO handshakes are
//   routed to the winner only. The tag comes back on tag_o with a one-cycle
//   done pulse on the winner's done_o bit.
//
// Ports
//   clk_i, rst_n_i               clock, async active-low reset
//   req_i / gnt_o / done_o       per-requester request level, one-hot grant, done pulse
//   tag_o                        tag of the last finished job (held)
//   key_i, nonce_i, *_size_i     per-requester config, slice i = [i*W +: W]
//   core_*_o (cfg), core_start_o latched config and start pulse to the core
//   core_ready_i, core_tag_*_i   core status and tag
//   ad_/pt_ data/empty/pop/flush per-requester input FIFOs <-> core-facing side
//   ct_full/push/flush           per-requester CT FIFO <-> core-facing side
//   dbg_state_o                  current FSM state (IDLE=0 LAUNCH=1 BUSY=2 DRAIN=3)
//
// Handshake semantics: core_start_o is asserted in LAUNCH only while
// core_ready_i is high, and the FSM leaves LAUNCH on that same edge. The start
// pulse is therefore exactly one cycle wide. core_tag_valid_i is a level. The
// tag is captured on its first high cycle in BUSY. The grant is held until the
// level drops and the winner has withdrawn its request.
module ascon_req_arbiter #(
  parameter int NumReq        = 2,
  parameter int DataAddrWidth = 7
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NumReq-1:0]               req_i,
  output logic [NumReq-1:0]               gnt_o,
  output logic [NumReq-1:0]               done_o,
  output logic [127:0]                    tag_o,
  input  logic [NumReq*128-1:0]           key_i,
  input  logic [NumReq*128-1:0]           nonce_i,
  input  logic [NumReq*DataAddrWidth-1:0] ad_size_i,
  input  logic [NumReq*DataAddrWidth-1:0] pt_size_i,
  output logic [127:0]                    core_key_o,
  output logic [127:0]                    core_nonce_o,
  output logic [DataAddrWidth-1:0]        core_ad_size_o,
  output logic [DataAddrWidth-1:0]        core_pt_size_o,
  output logic                            core_start_o,
  input  logic                            core_ready_i,
  input  logic                            core_tag_valid_i,
  input  logic [127:0]                    core_tag_i,
  input  logic [NumReq*64-1:0]            ad_data_i,
  input  logic [NumReq*64-1:0]            pt_data_i,
  input  logic [NumReq-1:0]               ad_empty_i,
  input  logic [NumReq-1:0]               pt_empty_i,
  output logic [NumReq-1:0]               ad_pop_o,
  output logic [NumReq-1:0]               pt_pop_o,
  output logic [NumReq-1:0]               ad_flush_o,
  output logic [NumReq-1:0]               pt_flush_o,
  output logic [63:0]                     core_ad_data_o,
  output logic [63:0]                     core_pt_data_o,
  output logic                            core_ad_empty_o,
  output logic                            core_pt_empty_o,
  input  logic                            core_ad_pop_i,
  input  logic                            core_pt_pop_i,
  input  logic                            core_ad_flush_i,
  input  logic                            core_pt_flush_i,
  input  logic [NumReq-1:0]               ct_full_i,
  output logic [NumReq-1:0]               ct_push_o,
  output logic [NumReq-1:0]               ct_flush_o,
  output logic                            core_ct_full_o,
  input  logic                            core_ct_push_i,
  input  logic                            core_ct_flush_i,
  output logic [1:0]                      dbg_state_o
);

  localparam int IdxW = $clog2(NumReq);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [IdxW-1:0]          ptr_q, g_q, win;
  logic [NumReq-1:0]        gnt_q, done_q, win_oh;
  logic [127:0]             tag_q, key_q, nonce_q;
  logic [DataAddrWidth-1:0] ad_size_q, pt_size_q;
  logic                     release_job, gnt_any;
  logic [IdxW-1:0]          next_ptr;

  // Round-robin pick. Scanning from the far end down to ptr means the last
  // hit is the one closest to ptr, which is the winner.
  always_comb begin
    win = ptr_q;
    for (int k = NumReq - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (req_i[idx]) win = IdxW'(idx);
    end
  end

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign release_job = !req_i[g_q] && !core_tag_valid_i;
  assign next_ptr    = (g_q == IdxW'(NumReq - 1)) ? '0 : g_q + 1'b1;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_i)           state_d = LAUNCH;
      LAUNCH:  if (core_ready_i)     state_d = BUSY;
      BUSY:    if (core_tag_valid_i) state_d = DRAIN;
      DRAIN:   if (release_job)      state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Grant, pointer, latched config and tag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q     <= '0;
      g_q       <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      tag_q     <= '0;
      key_q     <= '0;
      nonce_q   <= '0;
      ad_size_q <= '0;
      pt_size_q <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: if (|req_i) begin
          g_q       <= win;
          gnt_q     <= win_oh;
          key_q     <= key_i[win*128 +: 128];
          nonce_q   <= nonce_i[win*128 +: 128];
          ad_size_q <= ad_size_i[win*DataAddrWidth +: DataAddrWidth];
          pt_size_q <= pt_size_i[win*DataAddrWidth +: DataAddrWidth];
        end
        BUSY: if (core_tag_valid_i) begin
          tag_q       <= core_tag_i;
          done_q[g_q] <= 1'b1;
        end
        DRAIN: if (release_job) begin
          gnt_q <= '0;
          ptr_q <= next_ptr;
        end
        default: ;
      endcase
    end
  end

  // Outputs and routing. gnt_q is one-hot on g_q whenever it is non-zero,
  // so masking the core controls with it steers them to the winner only.
  always_comb begin
    gnt_any         = |gnt_q;
    core_start_o    = (state_q == LAUNCH) && core_ready_i;
    core_ad_data_o  = gnt_any ? ad_data_i[g_q*64 +: 64] : '0;
    core_pt_data_o  = gnt_any ? pt_data_i[g_q*64 +: 64] : '0;
    core_ad_empty_o = gnt_any ? ad_empty_i[g_q] : 1'b1;
    core_pt_empty_o = gnt_any ? pt_empty_i[g_q] : 1'b1;
    core_ct_full_o  = gnt_any ? ct_full_i[g_q]  : 1'b1;
    ad_pop_o        = gnt_q & {NumReq{core_ad_pop_i}};
    pt_pop_o        = gnt_q & {NumReq{core_pt_pop_i}};
    ad_flush_o      = gnt_q & {NumReq{core_ad_flush_i}};
    pt_flush_o      = gnt_q & {NumReq{core_pt_flush_i}};
    ct_push_o       = gnt_q & {NumReq{core_ct_push_i}};
    ct_flush_o      = gnt_q & {NumReq{core_ct_flush_i}};
  end

  assign gnt_o          = gnt_q;
  assign done_o         = done_q;
  assign tag_o          = tag_q;
  assign core_key_o     = key_q;
  assign core_nonce_o   = nonce_q;
  assign core_ad_size_o = ad_size_q;
  assign core_pt_size_o = pt_size_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ascon_req_arbiter.sv
// Testbench for ascon_req_arbiter: the bench plays the role of the ascon core
// and of two requesters. Expected grants and done/tag results are queued when
// a job is issued. A monitor pops and compares them when the DUT presents them.
module tb_ascon_req_arbiter;
  localparam int N  = 2;
  localparam int DW = 7;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]      req_i, gnt_o, done_o;
  logic [127:0]      tag_o;
  logic [N*128-1:0]  key_i, nonce_i;
  logic [N*DW-1:0]   ad_size_i, pt_size_i;
  logic [127:0]      core_key_o, core_nonce_o;
  logic [DW-1:0]     core_ad_size_o, core_pt_size_o;
  logic              core_start_o, core_ready_i, core_tag_valid_i;
  logic [127:0]      core_tag_i;
  logic [N*64-1:0]   ad_data_i, pt_data_i;
  logic [N-1:0]      ad_empty_i, pt_empty_i, ad_pop_o, pt_pop_o, ad_flush_o, pt_flush_o;
  logic [63:0]       core_ad_data_o, core_pt_data_o;
  logic              core_ad_empty_o, core_pt_empty_o;
  logic              core_ad_pop_i, core_pt_pop_i, core_ad_flush_i, core_pt_flush_i;
  logic [N-1:0]      ct_full_i, ct_push_o, ct_flush_o;
  logic              core_ct_full_o, core_ct_push_i, core_ct_flush_i;
  logic [1:0]        dbg_state_o;

  ascon_req_arbiter #(.NumReq(N), .DataAddrWidth(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .gnt_o(gnt_o), .done_o(done_o),
    .tag_o(tag_o), .key_i(key_i), .nonce_i(nonce_i), .ad_size_i(ad_size_i),
    .pt_size_i(pt_size_i), .core_key_o(core_key_o), .core_nonce_o(core_nonce_o),
    .core_ad_size_o(core_ad_size_o), .core_pt_size_o(core_pt_size_o),
    .core_start_o(core_start_o), .core_ready_i(core_ready_i),
    .core_tag_valid_i(core_tag_valid_i), .core_tag_i(core_tag_i),
    .ad_data_i(ad_data_i), .pt_data_i(pt_data_i), .ad_empty_i(ad_empty_i),
    .pt_empty_i(pt_empty_i), .ad_pop_o(ad_pop_o), .pt_pop_o(pt_pop_o),
    .ad_flush_o(ad_flush_o), .pt_flush_o(pt_flush_o),
    .core_ad_data_o(core_ad_data_o), .core_pt_data_o(core_pt_data_o),
    .core_ad_empty_o(core_ad_empty_o), .core_pt_empty_o(core_pt_empty_o),
    .core_ad_pop_i(core_ad_pop_i), .core_pt_pop_i(core_pt_pop_i),
    .core_ad_flush_i(core_ad_flush_i), .core_pt_flush_i(core_pt_flush_i),
    .ct_full_i(ct_full_i), .ct_push_o(ct_push_o), .ct_flush_o(ct_flush_o),
    .core_ct_full_o(core_ct_full_o), .core_ct_push_i(core_ct_push_i),
    .core_ct_flush_i(core_ct_flush_i), .dbg_state_o(dbg_state_o)
  );

  // Requester-side model values
  logic [127:0]  key_val[N], nonce_val[N];
  logic [DW-1:0] ad_sz[N], pt_sz[N];
  logic [63:0]   ad_val[N], pt_val[N];

  // Scoreboard
  logic [N+127:0] exp_q[$];
  logic [N-1:0]   exp_gnt_q[$];
  logic [N+127:0] e;
  logic [N-1:0]   eg;
  logic [N-1:0]   prev_gnt = '0;
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg();
    for (int i = 0; i < N; i++) begin
      key_i[i*128 +: 128]   = key_val[i];
      nonce_i[i*128 +: 128] = nonce_val[i];
      ad_size_i[i*DW +: DW] = ad_sz[i];
      pt_size_i[i*DW +: DW] = pt_sz[i];
      ad_data_i[i*64 +: 64] = ad_val[i];
      pt_data_i[i*64 +: 64] = pt_val[i];
    end
  endtask

  // Monitor: compares grant rises and done pulses against the queues
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if (gnt_o != '0 && prev_gnt == '0) begin
        if (exp_gnt_q.size() == 0) check("gnt_unexpected", gnt_o, '0);
        else begin
          eg = exp_gnt_q.pop_front();
          check("mon_gnt", gnt_o, eg);
        end
      end
      if (done_o != '0) begin
        if (exp_q.size() == 0) check("done_unexpected", done_o, '0);
        else begin
          e = exp_q.pop_front();
          check("mon_done", done_o, e[N+127:128]);
          check("mon_tag", tag_o, e[127:0]);
        end
      end
      prev_gnt = gnt_o;
    end
  end

  // Acts as the core for one job of requester r. The caller has raised req_i[r].
  task automatic do_job(input int r, input logic [127:0] tag, input int rdy_dly, input bit re_raise);
    logic [N-1:0] oh;
    logic [127:0] old_key;
    int n;
    oh = '0;
    oh[r] = 1'b1;
    exp_gnt_q.push_back(oh);
    exp_q.push_back({oh, tag});
    n = 0;
    while (gnt_o == '0 && n < 10) begin
      tick();
      n++;
    end
    check("gnt", gnt_o, oh);
    check("gnt_latency", n, 1);
    for (int k = 0; k < rdy_dly; k++) begin
      @(negedge clk);
      check("start_wait", core_start_o, 0);
      tick();
    end
    core_ready_i = 1'b1;
    @(negedge clk);
    check("start", core_start_o, 1);
    check("cfg_key", core_key_o, key_val[r]);
    check("cfg_nonce", core_nonce_o, nonce_val[r]);
    check("cfg_ad_size", core_ad_size_o, ad_sz[r]);
    check("cfg_pt_size", core_pt_size_o, pt_sz[r]);
    tick();
    @(negedge clk);
    check("start_len", core_start_o, 0);
    check("state_busy", dbg_state_o, 2);
    core_ready_i = 1'b0;
    // FIFO routing to the winner only
    tick();
    ad_empty_i = oh; pt_empty_i = ~oh; ct_full_i = ~oh;
    core_ad_pop_i = 1; core_pt_pop_i = 1; core_ad_flush_i = 1; core_pt_flush_i = 1;
    core_ct_push_i = 1; core_ct_flush_i = 1;
    #1;
    check("ad_pop", ad_pop_o, oh);
    check("pt_pop", pt_pop_o, oh);
    check("ad_flush", ad_flush_o, oh);
    check("pt_flush", pt_flush_o, oh);
    check("ct_push", ct_push_o, oh);
    check("ct_flush", ct_flush_o, oh);
    check("ad_empty", core_ad_empty_o, 1);
    check("pt_empty", core_pt_empty_o, 0);
    check("ct_full", core_ct_full_o, 0);
    check("ad_data", core_ad_data_o, ad_val[r]);
    check("pt_data", core_pt_data_o, pt_val[r]);
    core_ad_pop_i = 0; core_pt_pop_i = 0; core_ad_flush_i = 0; core_pt_flush_i = 0;
    core_ct_push_i = 0; core_ct_flush_i = 0;
    ad_empty_i = ~oh;
    #1;
    check("ad_pop_idle", ad_pop_o, 0);
    check("ad_empty_low", core_ad_empty_o, 0);
    // Mid-job config change must not reach the core
    old_key = key_val[r];
    key_val[r] = {old_key[63:0], old_key[127:64]} ^ 128'h1;
    drive_cfg();
    tick();
    @(negedge clk);
    check("key_frozen", core_key_o, old_key);
    // Tag handoff
    tick();
    core_tag_valid_i = 1'b1;
    core_tag_i = tag;
    tick();
    @(negedge clk);
    req_i[r] = 1'b0;
    core_tag_i = ~tag;
    tick();
    @(negedge clk);
    check("drain_hold", gnt_o, oh);
    check("tag_hold", tag_o, tag);
    check("state_drain", dbg_state_o, 3);
    core_tag_valid_i = 1'b0;
    tick();
    if (re_raise) req_i[r] = 1'b1;
    @(negedge clk);
    check("release", gnt_o, 0);
    check("state_idle", dbg_state_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_i = '0; core_ready_i = 0; core_tag_valid_i = 0; core_tag_i = '0;
    ad_empty_i = '0; pt_empty_i = '0; ct_full_i = '0;
    core_ad_pop_i = 0; core_pt_pop_i = 0; core_ad_flush_i = 0; core_pt_flush_i = 0;
    core_ct_push_i = 0; core_ct_flush_i = 0;
    key_val[0]   = 128'h000102030405060708090a0b0c0d0e0f;
    key_val[1]   = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    nonce_val[0] = 128'h11112222333344445555666677778888;
    nonce_val[1] = 128'h9999aaaabbbbccccddddeeeeffff0000;
    ad_sz[0] = 7'd3;  ad_sz[1] = 7'd5;
    pt_sz[0] = 7'd4;  pt_sz[1] = 7'd9;
    ad_val[0] = 64'had00_0000_0000_0a00; ad_val[1] = 64'had11_1111_1111_1a11;
    pt_val[0] = 64'hb700_0000_0000_0b00; pt_val[1] = 64'hb711_1111_1111_1b11;
    drive_cfg();

    // Reset state
    repeat (2) @(posedge clk);
    core_ad_pop_i = 1;
    @(negedge clk);
    check("rst_gnt", gnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_start", core_start_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_key", core_key_o, 0);
    check("rst_ad_pop", ad_pop_o, 0);
    check("rst_ad_empty", core_ad_empty_o, 1);
    check("rst_ct_full", core_ct_full_o, 1);
    check("rst_ad_data", core_ad_data_o, 0);
    check("rst_state", dbg_state_o, 0);
    core_ad_pop_i = 0;
    tick();
    rst_n = 1'b1;

    // Both requesting: order 0,1,0,1
    req_i = 2'b11;
    do_job(0, 128'h0123456789abcdef0123456789abcdef, 0, 1);
    do_job(1, 128'hfedcba9876543210fedcba9876543210, 0, 1);
    do_job(0, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 0, 0);
    do_job(1, 128'h5555aaaa5555aaaa5555aaaa5555aaaa, 0, 0);

    // Requester 1 alone, core not ready for 5 cycles
    req_i = 2'b10;
    do_job(1, 128'hdeadbeefdeadbeefdeadbeefdeadbeef, 5, 0);

    // Requester 0 alone, A5 tag
    req_i = 2'b01;
    do_job(0, {16{8'ha5}}, 0, 0);
    check("tag_a5_held", tag_o, {16{8'ha5}});

    // Async reset during BUSY, then restart from pointer 0
    req_i = 2'b10;
    exp_gnt_q.push_back(2'b10);
    tick();
    check("t6_gnt", gnt_o, 2'b10);
    core_ready_i = 1'b1;
    tick();
    core_ready_i = 1'b0;
    tick();
    check("t6_busy", dbg_state_o, 2);
    rst_n = 1'b0;
    #1;
    check("t6_gnt_rst", gnt_o, 0);
    check("t6_done_rst", done_o, 0);
    check("t6_start_rst", core_start_o, 0);
    check("t6_state_rst", dbg_state_o, 0);
    check("t6_tag_rst", tag_o, 0);
    check("t6_key_rst", core_key_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    req_i = 2'b11;
    do_job(0, 128'h13579bdf2468ace013579bdf2468ace0, 1, 0);
    do_job(1, 128'h0badc0de0badc0de0badc0de0badc0de, 0, 0);

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_gnt_q_drained", exp_gnt_q.size(), 0);
    check("final_gnt", gnt_o, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
